// File: rtl/sdram_port_arbiter.sv
// Burst command scheduler sharing the SDRAM between a write FIFO and a read FIFO.
// Issues WRITEA/READA with wrapping frame pointers, fair alternation and a NOP gap between commands.
module sdram_port_arbiter #(
    parameter int ASIZE   = 23,
    parameter int BURST   = 8,
    parameter int FW      = 10,
    parameter int RD_LOW  = 16,
    parameter int WR_BASE = 0,
    parameter int WR_MAX  = 307200,
    parameter int RD_BASE = 0,
    parameter int RD_MAX  = 307200,
    parameter int GAP_CYC = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             Sdram_Init_Done,
    input  logic             CMD_ACK,
    input  logic [FW-1:0]    wr_usedw,
    input  logic [FW-1:0]    rd_usedw,
    input  logic             wr_load,
    input  logic             rd_load,
    output logic [2:0]       CMD,
    output logic [ASIZE-1:0] ADDR,
    output logic             wr_busy,
    output logic             rd_busy,
    output logic             wr_wrap,
    output logic             rd_wrap
);

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam logic [2:0]       CMD_NOP   = 3'b000;
    localparam logic [2:0]       CMD_READ  = 3'b001;
    localparam logic [2:0]       CMD_WRITE = 3'b010;
    localparam logic [FW-1:0]    BURST_FW  = FW'(BURST);
    localparam logic [FW-1:0]    RD_LOW_FW = FW'(RD_LOW);
    localparam logic [ASIZE:0]   BURST_A   = (ASIZE+1)'(BURST);
    localparam logic [ASIZE:0]   WR_MAX_A  = (ASIZE+1)'(WR_MAX);
    localparam logic [ASIZE:0]   RD_MAX_A  = (ASIZE+1)'(RD_MAX);
    localparam logic [ASIZE-1:0] WR_BASE_A = ASIZE'(WR_BASE);
    localparam logic [ASIZE-1:0] RD_BASE_A = ASIZE'(RD_BASE);
    localparam logic [7:0]       GAP_LAST  = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t           state_r, state_s;
    logic [2:0]       cmd_r, cmd_s;
    logic [ASIZE-1:0] addr_r, addr_s;
    logic             wr_busy_r, wr_busy_s, rd_busy_r, rd_busy_s;
    logic             wr_wrap_r, wr_wrap_s, rd_wrap_r, rd_wrap_s;
    logic [ASIZE-1:0] wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic             wr_pend_r, wr_pend_s, rd_pend_r, rd_pend_s;
    logic             last_rd_r, last_rd_s;
    logic [7:0]       gap_cnt_r, gap_cnt_s;
    logic             wr_req_s, rd_req_s;
    logic [ASIZE:0]   sum_s;

    assign wr_req_s = (wr_usedw >= BURST_FW);
    assign rd_req_s = (rd_usedw < RD_LOW_FW);
    // Advance is taken from the address being acknowledged, one bit wider so the wrap compare cannot overflow.
    assign sum_s    = {1'b0, addr_r} + BURST_A;

    // Next-state, command and pointer logic.
    always_comb begin
        state_s   = state_r;
        cmd_s     = cmd_r;
        addr_s    = addr_r;
        wr_busy_s = wr_busy_r;
        rd_busy_s = rd_busy_r;
        wr_wrap_s = 1'b0;
        rd_wrap_s = 1'b0;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        wr_pend_s = wr_pend_r;
        rd_pend_s = rd_pend_r;
        last_rd_s = last_rd_r;
        gap_cnt_s = gap_cnt_r;
        if (!Sdram_Init_Done) begin
            state_s   = WAIT_INIT;
            cmd_s     = CMD_NOP;
            wr_busy_s = 1'b0;
            rd_busy_s = 1'b0;
            wr_pend_s = 1'b0;
            rd_pend_s = 1'b0;
        end else begin
            case (state_r)
                WAIT_INIT: state_s = IDLE;
                IDLE: begin
                    if (wr_req_s && (!rd_req_s || last_rd_r)) begin
                        cmd_s     = CMD_WRITE;
                        addr_s    = wr_ptr_r;
                        wr_busy_s = 1'b1;
                        state_s   = ISSUE;
                    end else if (rd_req_s) begin
                        cmd_s     = CMD_READ;
                        addr_s    = rd_ptr_r;
                        rd_busy_s = 1'b1;
                        state_s   = ISSUE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ISSUE: begin
                    if (CMD_ACK) begin
                        cmd_s     = CMD_NOP;
                        wr_busy_s = 1'b0;
                        rd_busy_s = 1'b0;
                        wr_pend_s = 1'b0;
                        rd_pend_s = 1'b0;
                        gap_cnt_s = 8'd0;
                        state_s   = GAP;
                        // A restart requested while the command was in flight wins over the advance.
                        if (wr_busy_r) begin
                            last_rd_s = 1'b0;
                            if (sum_s >= WR_MAX_A) begin
                                wr_ptr_s  = WR_BASE_A;
                                wr_wrap_s = 1'b1;
                            end else if (wr_pend_r) begin
                                wr_ptr_s = WR_BASE_A;
                            end else begin
                                wr_ptr_s = sum_s[ASIZE-1:0];
                            end
                        end else begin
                            last_rd_s = 1'b1;
                            if (sum_s >= RD_MAX_A) begin
                                rd_ptr_s  = RD_BASE_A;
                                rd_wrap_s = 1'b1;
                            end else if (rd_pend_r) begin
                                rd_ptr_s = RD_BASE_A;
                            end else begin
                                rd_ptr_s = sum_s[ASIZE-1:0];
                            end
                        end
                    end else begin
                        wr_pend_s = wr_pend_r | wr_load;
                        rd_pend_s = rd_pend_r | rd_load;
                    end
                end
                GAP: begin
                    if (gap_cnt_r >= GAP_LAST) begin
                        state_s = IDLE;
                    end else begin
                        gap_cnt_s = gap_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_s   = WAIT_INIT;
                    cmd_s     = CMD_NOP;
                    wr_busy_s = 1'b0;
                    rd_busy_s = 1'b0;
                end
            endcase
        end
        wr_ptr_s = wr_load ? WR_BASE_A : wr_ptr_s;
        rd_ptr_s = rd_load ? RD_BASE_A : rd_ptr_s;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= WAIT_INIT;
            cmd_r     <= CMD_NOP;
            addr_r    <= '0;
            wr_busy_r <= 1'b0;
            rd_busy_r <= 1'b0;
            wr_wrap_r <= 1'b0;
            rd_wrap_r <= 1'b0;
            wr_ptr_r  <= WR_BASE_A;
            rd_ptr_r  <= RD_BASE_A;
            wr_pend_r <= 1'b0;
            rd_pend_r <= 1'b0;
            last_rd_r <= 1'b1;
            gap_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_s;
            cmd_r     <= cmd_s;
            addr_r    <= addr_s;
            wr_busy_r <= wr_busy_s;
            rd_busy_r <= rd_busy_s;
            wr_wrap_r <= wr_wrap_s;
            rd_wrap_r <= rd_wrap_s;
            wr_ptr_r  <= wr_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
            wr_pend_r <= wr_pend_s;
            rd_pend_r <= rd_pend_s;
            last_rd_r <= last_rd_s;
            gap_cnt_r <= gap_cnt_s;
        end
    end

    assign CMD     = cmd_r;
    assign ADDR    = addr_r;
    assign wr_busy = wr_busy_r;
    assign rd_busy = rd_busy_r;
    assign wr_wrap = wr_wrap_r;
    assign rd_wrap = rd_wrap_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected commands are queued with the stimulus
// and popped as the arbiter presents each command.
module tb_sdram_port_arbiter;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n, init_done, cmd_ack, wr_load, rd_load;
    logic [9:0]  wr_usedw, rd_usedw;
    logic [2:0]  cmd;
    logic [22:0] addr;
    logic        wr_busy, rd_busy, wr_wrap, rd_wrap;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [22:0] addr;
        logic        ww;
        logic        rw;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    sdram_port_arbiter #(.WR_MAX(32), .RD_MAX(24), .GAP_CYC(GAP)) dut (
        .CLK(clk), .RESET_N(rst_n), .Sdram_Init_Done(init_done), .CMD_ACK(cmd_ack),
        .wr_usedw(wr_usedw), .rd_usedw(rd_usedw), .wr_load(wr_load), .rd_load(rd_load),
        .CMD(cmd), .ADDR(addr), .wr_busy(wr_busy), .rd_busy(rd_busy),
        .wr_wrap(wr_wrap), .rd_wrap(rd_wrap)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] c, input int a, input bit ww, input bit rw);
        exp_t e;
        e.cmd  = c;
        e.addr = 23'(a);
        e.ww   = ww;
        e.rw   = rw;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cmd_ack = 1'b0;
        wr_load = 1'b0;
        rd_load = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        check_eq("reset_cmd_addr", {6'd0, cmd, addr}, 32'd0);
        check_eq("reset_flags", {wr_busy, rd_busy, wr_wrap, rd_wrap}, 4'b0000);
        rst_n = 1'b1;
    endtask

    // Waits for the next command, counting NOP samples, then compares it with the scoreboard head.
    task automatic wait_cmd(input int gap_exp, output exp_t e, output bit ok, output int n);
        n  = 0;
        ok = 1'b0;
        e  = '0;
        @(negedge clk);
        check_eq("wrap_pulse_len", {wr_wrap, rd_wrap}, 2'b00);
        while (cmd == 3'b000 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_eq("cmd_timeout", (cmd != 3'b000), 1'b1);
        if (cmd == 3'b000) return;
        if (q.size() == 0) begin
            check_eq("queue_empty", 32'd0, 32'd1);
            return;
        end
        ok = 1'b1;
        e  = q.pop_front();
        check_eq("cmd", cmd, e.cmd);
        check_eq("addr", addr, e.addr);
        check_eq("wr_busy", wr_busy, (e.cmd == 3'b010));
        check_eq("rd_busy", rd_busy, (e.cmd == 3'b001));
        if (gap_exp >= 0) check_eq("gap_nops", n, gap_exp);
    endtask

    // Holds the command for dly cycles (optionally pulsing wr_load), acknowledges it and checks the aftermath.
    task automatic ack_cmd(input exp_t e, input int dly, input bit ld);
        bit stable;
        stable = 1'b1;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (cmd !== e.cmd || addr !== e.addr || wr_busy !== (e.cmd == 3'b010) ||
                rd_busy !== (e.cmd == 3'b001)) stable = 1'b0;
            wr_load = ld && (i == 1);
        end
        check_eq("hold_stable", stable, 1'b1);
        wr_load = 1'b0;
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check_eq("post_ack_cmd", cmd, 3'b000);
        check_eq("post_ack_busy", {wr_busy, rd_busy}, 2'b00);
        check_eq("post_ack_wrap", {wr_wrap, rd_wrap}, {e.ww, e.rw});
    endtask

    task automatic serve(input int gap_exp, input int dly, input bit ld);
        exp_t e;
        bit   ok;
        int   n;
        wait_cmd(gap_exp, e, ok, n);
        if (ok) ack_cmd(e, dly, ld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   ok;
        int   n;
        int   nz;

        // Held in WAIT_INIT while init is incomplete, then write-only stream with a wrap at 32.
        init_done = 1'b0;
        wr_usedw  = 10'd100;
        rd_usedw  = 10'd100;
        do_reset();
        nz = 0;
        repeat (50) begin
            @(negedge clk);
            if (cmd != 3'b000) nz++;
        end
        check_eq("wait_init_nop", nz, 0);
        init_done = 1'b1;
        push(3'b010, 0, 1'b0, 1'b0);
        push(3'b010, 8, 1'b0, 1'b0);
        push(3'b010, 16, 1'b0, 1'b0);
        push(3'b010, 24, 1'b1, 1'b0);
        push(3'b010, 0, 1'b0, 1'b0);
        wait_cmd(-1, e, ok, n);
        check_eq("init_latency", (n <= 2), 1'b1);
        if (ok) ack_cmd(e, 5, 1'b0);
        repeat (4) serve(GAP, 5, 1'b0);

        // Both ports requesting: write first, then strict alternation; read wraps at 24.
        wr_usedw = 10'd100;
        rd_usedw = 10'd0;
        do_reset();
        push(3'b010, 0, 1'b0, 1'b0);
        push(3'b001, 0, 1'b0, 1'b0);
        push(3'b010, 8, 1'b0, 1'b0);
        push(3'b001, 8, 1'b0, 1'b0);
        push(3'b010, 16, 1'b0, 1'b0);
        push(3'b001, 16, 1'b0, 1'b1);
        serve(-1, 2, 1'b0);
        repeat (5) serve(GAP, 2, 1'b0);

        // Write pointer restart while the command at 16 is outstanding.
        rd_usedw = 10'd100;
        do_reset();
        push(3'b010, 0, 1'b0, 1'b0);
        push(3'b010, 8, 1'b0, 1'b0);
        push(3'b010, 16, 1'b0, 1'b0);
        push(3'b010, 0, 1'b0, 1'b0);
        serve(-1, 5, 1'b0);
        serve(GAP, 5, 1'b0);
        serve(GAP, 5, 1'b1);
        serve(GAP, 5, 1'b0);

        // Init drop mid-command abandons it; the pointer is kept for the re-issue.
        push(3'b010, 8, 1'b0, 1'b0);
        wait_cmd(GAP, e, ok, n);
        init_done = 1'b0;
        @(negedge clk);
        check_eq("init_drop_cmd", cmd, 3'b000);
        check_eq("init_drop_busy", {wr_busy, rd_busy}, 2'b00);
        init_done = 1'b1;
        push(3'b010, 8, 1'b0, 1'b0);
        wait_cmd(-1, e, ok, n);

        // Asynchronous reset in the middle of ISSUE, then grants restart from the bases.
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_cmd_addr", {6'd0, cmd, addr}, 32'd0);
        check_eq("async_rst_flags", {wr_busy, rd_busy, wr_wrap, rd_wrap}, 4'b0000);
        rd_usedw = 10'd0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push(3'b010, 0, 1'b0, 1'b0);
        push(3'b001, 0, 1'b0, 1'b0);
        serve(-1, 3, 1'b0);
        serve(GAP, 3, 1'b0);
        check_eq("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
